// File: rtl/front_end_reader_if.sv
// Memory read port and output stream bundle for the front end reader.
// master = reader side, slave = memory/stream sink side.
interface front_end_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              rden;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;

  modport master (
    output rden,
    output addr,
    input  rdata,
    output dout,
    output dout_valid,
    input  dout_ready,
    output dout_last
  );

  modport slave (
    input  rden,
    input  addr,
    output rdata,
    input  dout,
    input  dout_valid,
    output dout_ready,
    input  dout_last
  );
endinterface

// File: rtl/front_end_reader.sv
// Streams SIZE words from the local input memory to the datapath,
// flagging the last word and reporting idle/done to the control logic.
module front_end_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                start,
  input  logic [ADDR_W:0]     size,
  front_end_reader_if.master  bus,
  output logic                idle,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] ONE = 1;

  state_t            state;
  logic [ADDR_W:0]   size_q;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   pop_cnt;
  logic [ADDR_W:0]   size_m1;
  logic              inflight;
  logic [1:0]        occ;
  logic              rp;
  logic              wp;
  logic [DATA_W-1:0] fifo [2];
  logic              pop;
  logic              issue;
  logic              credit;

  // A read may only launch if its data is sure to find a free slot.
  always_comb begin
    size_m1 = size_q - ONE;
    pop     = (occ != 2'd0) & bus.dout_ready;
    credit  = (occ == 2'd0)
            | ((occ == 2'd1) & ~inflight)
            | pop;
    issue   = (state == READ) & (rd_cnt < size_q) & credit;
  end

  assign bus.rden       = issue;
  assign bus.addr       = rd_cnt[ADDR_W-1:0];
  assign bus.dout_valid = (occ != 2'd0);
  assign bus.dout       = fifo[rp];
  assign bus.dout_last  = (occ != 2'd0) & (pop_cnt == size_m1);
  assign idle           = (state == IDLE);
  assign done           = (state == DONE);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= IDLE;
      size_q   <= '0;
      rd_cnt   <= '0;
      pop_cnt  <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      rp       <= 1'b0;
      wp       <= 1'b0;
      fifo[0]  <= '0;
      fifo[1]  <= '0;
    end else begin
      inflight <= issue;
      if (issue)
        rd_cnt <= rd_cnt + ONE;
      if (inflight) begin
        fifo[wp] <= bus.rdata;
        wp       <= ~wp;
      end
      if (pop) begin
        rp      <= ~rp;
        pop_cnt <= pop_cnt + ONE;
      end
      unique case (1'b1)
        inflight & ~pop: occ <= occ + 2'd1;
        ~inflight & pop: occ <= occ - 2'd1;
        default:         occ <= occ;
      endcase
      unique case (state)
        IDLE: begin
          if (start) begin
            size_q  <= size;
            rd_cnt  <= '0;
            pop_cnt <= '0;
            state   <= (size == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (issue && rd_cnt == size_m1)
            state <= DRAIN;
        end
        DRAIN: begin
          if (pop && bus.dout_last)
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_front_end_reader.sv
// Directed/random bench for front_end_reader: memory model plus
// expected stream = mem[0..size-1] in order.
module tb_front_end_reader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic          aclk;
  logic          areset;
  logic          start;
  logic [AW:0]   size;
  logic          idle;
  logic          done;
  logic [DW-1:0] mem [DEPTH];

  front_end_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  front_end_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .start  (start),
    .size   (size),
    .bus    (bus),
    .idle   (idle),
    .done   (done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk)
    if (bus.rden) bus.rdata <= mem[bus.addr];

  int total = 0;
  int bad = 0;
  int k, issued, popped, done_cnt, last_cnt, cur_size;
  int first_rd, last_rd_k, first_v, last_k, done_k, idle_k;
  int last_addr;
  logic          hold_v;
  logic [DW-1:0] hold_d;
  logic          hold_l;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats(int sz);
    k = 0; issued = 0; popped = 0; done_cnt = 0; last_cnt = 0;
    first_rd = -1; last_rd_k = -1; first_v = -1; last_k = -1;
    done_k = -1; idle_k = -1; last_addr = -1; hold_v = 1'b0;
    cur_size = sz;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
  endtask

  // One cycle: observe at negedge, then advance past the next posedge.
  task automatic step();
    @(negedge aclk);
    if (hold_v) begin
      chk("hold_valid", bus.dout_valid, 1);
      chk("hold_data", bus.dout, hold_d);
      chk("hold_last", bus.dout_last, hold_l);
    end
    if (bus.rden) begin
      chk("addr", bus.addr, issued);
      if (issued == 0) first_rd = k;
      last_rd_k = k;
      last_addr = bus.addr;
      issued++;
    end
    if (bus.dout_valid && first_v < 0) first_v = k;
    if (bus.dout_valid && bus.dout_ready) begin
      chk("data", bus.dout, (popped < DEPTH) ? mem[popped] : 'x);
      chk("last_flag", bus.dout_last, popped == cur_size - 1);
      if (bus.dout_last) begin
        last_cnt++;
        last_k = k;
      end
      popped++;
    end
    chk("outstanding", (issued - popped) <= 2, 1);
    chk("idle_done_excl", done & idle, 0);
    if (done) begin
      done_cnt++;
      done_k = k;
    end
    if (idle && done_k >= 0 && idle_k < 0) idle_k = k;
    hold_v = bus.dout_valid & ~bus.dout_ready;
    hold_d = bus.dout;
    hold_l = bus.dout_last;
    @(posedge aclk);
    #1;
    k++;
  endtask

  // mode 0: ready high, 1: random, 2: low in cycles 3..10
  task automatic run_xfer(int sz, int mode, bit glitch);
    fill_mem();
    clear_stats(sz);
    while (done_cnt == 0 && k < 6000) begin
      start = (k == 0) || (glitch && (k == 2 || k == sz + 3));
      size  = (k == 0) ? (AW+1)'(sz) : (AW+1)'(1);
      case (mode)
        0:       bus.dout_ready = 1'b1;
        1:       bus.dout_ready = 1'($urandom_range(0, 1));
        default: bus.dout_ready = !(k >= 3 && k <= 10);
      endcase
      step();
    end
    start = 1'b0;
    bus.dout_ready = 1'b1;
    chk("done_seen", done_cnt, 1);
    chk("popped", popped, sz);
    chk("issued", issued, sz);
    chk("last_once", last_cnt, (sz != 0) ? 1 : 0);
    for (int i = 0; i < 3; i++) step();
    chk("idle_after_done", idle_k, done_k + 1);
    chk("single_done", done_cnt, 1);
  endtask

  initial begin
    areset = 1'b1;
    start = 1'b0;
    size = '0;
    bus.dout_ready = 1'b0;
    fill_mem();
    clear_stats(0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_rden", bus.rden, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_valid", bus.dout_valid, 0);
    chk("rst_last", bus.dout_last, 0);
    chk("rst_done", done, 0);
    chk("rst_idle", idle, 1);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // size 4, ready high: exact latency
    run_xfer(4, 0, 1'b0);
    chk("s4_first_rd", first_rd, 1);
    chk("s4_last_rd", last_rd_k, 4);
    chk("s4_first_v", first_v, 3);
    chk("s4_last_k", last_k, 6);
    chk("s4_done_k", done_k, 7);
    chk("s4_idle_k", idle_k, 8);

    // size 0: straight to done
    run_xfer(0, 0, 1'b0);
    chk("s0_no_valid", first_v, -1);
    chk("s0_done_k", done_k, 1);
    chk("s0_idle_k", idle_k, 2);

    // size 8 with a backpressure window
    run_xfer(8, 2, 1'b0);
    chk("s8_last_k_ok", last_k > 10, 1);

    // full-size transfer, random ready
    run_xfer(DEPTH, 1, 1'b0);
    chk("big_last_addr", last_addr, DEPTH - 1);

    // reset in DRAIN with two words buffered
    fill_mem();
    clear_stats(2);
    start = 1'b1;
    size = (AW+1)'(2);
    bus.dout_ready = 1'b0;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("pre_rst_issued", issued, 2);
    areset = 1'b1;
    step();
    chk("pre_rst_valid", first_v >= 0, 1);
    areset = 1'b0;
    hold_v = 1'b0;
    @(negedge aclk);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_valid", bus.dout_valid, 0);
    chk("mid_rst_rden", bus.rden, 0);
    chk("mid_rst_done", done, 0);
    @(posedge aclk);
    #1;
    bus.dout_ready = 1'b1;
    repeat (3) step();
    chk("mid_rst_no_done", done_cnt, 0);
    run_xfer(3, 0, 1'b0);

    // start pulses in READ and DONE are ignored
    run_xfer(5, 0, 1'b1);
    chk("glitch_done_k", done_k, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
